// File: rtl/fpgapu_pkg.sv
// Shared types for the note scheduling path: voice state encoding and the note length width.
package fpgapu_pkg;

  localparam int NOTE_LEN_W = 5;

  typedef enum logic [2:0] {
    V_IDLE,
    V_REQ,
    V_WAIT,
    V_PLAYING,
    V_STOPPED
  } voice_state_e;

endpackage

// File: rtl/note_voice_timer.sv
// One voice: strobes its sequencer, captures the note length, counts it down in ticks.
// Strobe is combinational from REQ; key_on/gate/stopped are registered; no backpressure, a silent sequencer times out.
module note_voice_timer
  import fpgapu_pkg::*;
#(
  parameter int LEN_W         = NOTE_LEN_W,
  parameter int VALID_TIMEOUT = 31
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_tick,
  input  logic             i_note_valid,
  input  logic [LEN_W-1:0] i_note_len,
  output logic             o_note_stb,
  output logic             o_key_on,
  output logic             o_gate,
  output logic             o_stopped
);

  localparam int TO_W = $clog2(VALID_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(VALID_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  voice_state_e     state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             key_on_q, key_on_d;
  logic             gate_q, gate_d;
  logic             stopped_q, stopped_d;
  logic [TO_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    key_on_d  = 1'b0;
    gate_d    = gate_q;
    stopped_d = stopped_q;
    case (state_q)
      V_IDLE: if (i_run) state_d = V_REQ;
      V_REQ: begin
        state_d = V_WAIT;
        cnt_d   = '0;
      end
      V_WAIT: begin
        if (i_note_valid) begin
          // a zero length would never expire, so it plays one tick
          rem_d    = (i_note_len == '0) ? LEN_ONE : i_note_len;
          key_on_d = 1'b1;
          gate_d   = 1'b1;
          state_d  = V_PLAYING;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TO_LAST) begin
            state_d   = V_STOPPED;
            stopped_d = 1'b1;
          end
        end
      end
      V_PLAYING: begin
        if (i_tick) begin
          if (rem_q == LEN_ONE) begin
            state_d = V_REQ;
            gate_d  = 1'b0;
          end else begin
            rem_d = rem_q - LEN_ONE;
          end
        end
      end
      V_STOPPED: state_d = V_STOPPED;
      default:   state_d = V_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= V_IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      key_on_q  <= 1'b0;
      gate_q    <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      key_on_q  <= key_on_d;
      gate_q    <= gate_d;
      stopped_q <= stopped_d;
    end
  end

  assign o_note_stb = (state_q == V_REQ);
  assign o_key_on   = key_on_q;
  assign o_gate     = gate_q;
  assign o_stopped  = stopped_q;

endmodule

// File: rtl/note_scheduler.sv
// Tempo tick divider plus one note_voice_timer per voice; sole source of each sequencer's strobe.
// o_tick is combinational from the divider count; a strobe follows a note's last tick by one clock; no backpressure.
module note_scheduler
  import fpgapu_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int LEN_W         = NOTE_LEN_W,
  parameter int VALID_TIMEOUT = 31
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic [15:0]             i_tick_period,
  output logic                    o_tick,
  output logic [NUM_CH-1:0]       o_note_stb,
  input  logic [NUM_CH-1:0]       i_note_valid,
  input  logic [NUM_CH*LEN_W-1:0] i_note_len,
  output logic [NUM_CH-1:0]       o_key_on,
  output logic [NUM_CH-1:0]       o_gate,
  output logic [NUM_CH-1:0]       o_stopped
);

  logic [15:0] div_q, div_d;
  logic [15:0] period_m1;
  logic        at_last;

  assign period_m1 = (i_tick_period == 16'd0) ? 16'd0 : i_tick_period - 16'd1;
  // >= rather than == so a period shortened below the current count still wraps at once
  assign at_last   = (div_q >= period_m1);
  assign o_tick    = i_run & ~i_rst & at_last;

  always_comb begin
    div_d = div_q;
    if (i_run) div_d = at_last ? 16'd0 : div_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) div_q <= 16'd0;
    else       div_q <= div_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_voice
    note_voice_timer #(
      .LEN_W        (LEN_W),
      .VALID_TIMEOUT(VALID_TIMEOUT)
    ) u_voice (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_run       (i_run),
      .i_tick      (o_tick),
      .i_note_valid(i_note_valid[k]),
      .i_note_len  (i_note_len[k*LEN_W +: LEN_W]),
      .o_note_stb  (o_note_stb[k]),
      .o_key_on    (o_key_on[k]),
      .o_gate      (o_gate[k]),
      .o_stopped   (o_stopped[k])
    );
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: sequencer stubs, directed timing scenarios and a random soak against a reference model.
module tb_note_scheduler;

  localparam int NUM_CH = 3;
  localparam int LEN_W  = 5;
  localparam int VT     = 31;

  localparam int M_IDLE = 0, M_ASK = 1, M_LISTEN = 2, M_PLAY = 3, M_DEAD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, run;
  logic [15:0]             period;
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH*LEN_W-1:0] len;
  logic                    tick;
  logic [NUM_CH-1:0]       stb, key_on, gate, stopped;

  note_scheduler #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .VALID_TIMEOUT(VT)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_tick_period(period), .o_tick(tick),
    .o_note_stb(stb), .i_note_valid(valid), .i_note_len(len), .o_key_on(key_on),
    .o_gate(gate), .o_stopped(stopped)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  int m_cnt;
  int m_mode[NUM_CH], m_left[NUM_CH], m_waited[NUM_CH];
  bit m_keyon[NUM_CH];
  bit model_ok = 0;

  // sequencer stubs and configuration
  int resp[NUM_CH], resp_len_v[NUM_CH];
  int cfg_delay[NUM_CH], cfg_len[NUM_CH];
  bit cfg_dead[NUM_CH];
  int spur;       // 0 none, 1 only while gate high, 2 any time
  bit rand_drop;

  // event records
  int cyc = 0;
  int stb_cnt[NUM_CH], first_stb[NUM_CH], last_stb[NUM_CH], keyon_cyc[NUM_CH];
  int stop_cyc[NUM_CH], gate_ticks[NUM_CH], gate_hi[NUM_CH];
  int last_tick, tick_total;
  logic [NUM_CH-1:0] stb_vec_last;
  logic [12:0] last_outs;

  task automatic step();
    int p, l;
    bit e_tick;
    logic [NUM_CH-1:0] e_stb, e_gate, e_key, e_stop;
    len = {$urandom, $urandom};
    for (int k = 0; k < NUM_CH; k++) begin
      valid[k] = 1'b0;
      if (resp[k] > 0) begin
        resp[k]--;
        if (resp[k] == 0) begin
          valid[k] = 1'b1;
          len[k*LEN_W +: LEN_W] = LEN_W'(resp_len_v[k]);
          resp[k] = -1;
        end
      end else if ((spur == 2 || (spur == 1 && gate[k])) && $urandom_range(0, 3) == 0) begin
        valid[k] = 1'b1;
      end
    end
    #1;
    p = (period == 0) ? 1 : int'(period);
    e_tick = run && !rst && (m_cnt >= p - 1);
    for (int k = 0; k < NUM_CH; k++) begin
      e_stb[k]  = (m_mode[k] == M_ASK);
      e_gate[k] = (m_mode[k] == M_PLAY);
      e_key[k]  = m_keyon[k];
      e_stop[k] = (m_mode[k] == M_DEAD);
    end
    last_outs = {tick, stb, gate, key_on, stopped};
    if (model_ok) chk("outs", 32'(last_outs), 32'({e_tick, e_stb, e_gate, e_key, e_stop}));

    if (tick) begin
      tick_total++;
      last_tick = cyc;
    end
    if (|stb) stb_vec_last = stb;
    for (int k = 0; k < NUM_CH; k++) begin
      if (stb[k]) begin
        stb_cnt[k]++;
        if (first_stb[k] < 0) first_stb[k] = cyc;
        last_stb[k] = cyc;
        if (!cfg_dead[k] && !(rand_drop && $urandom_range(0, 29) == 0)) begin
          resp[k]       = (cfg_delay[k] < 0) ? int'($urandom_range(4, 6)) : cfg_delay[k];
          resp_len_v[k] = (cfg_len[k] < 0) ? int'($urandom_range(0, 4)) : cfg_len[k];
        end
      end
      if (key_on[k]) begin
        keyon_cyc[k]  = cyc;
        gate_ticks[k] = 0;
      end
      if (gate[k]) gate_hi[k]++;
      if (gate[k] && tick) gate_ticks[k]++;
      if (stopped[k] && stop_cyc[k] < 0) stop_cyc[k] = cyc;
    end

    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_mode[k] = M_IDLE; m_left[k] = 0; m_waited[k] = 0; m_keyon[k] = 0; resp[k] = -1;
      end
    end else begin
      if (run) m_cnt = e_tick ? 0 : m_cnt + 1;
      for (int k = 0; k < NUM_CH; k++) begin
        m_keyon[k] = 0;
        case (m_mode[k])
          M_IDLE: if (run) m_mode[k] = M_ASK;
          M_ASK: begin m_mode[k] = M_LISTEN; m_waited[k] = 0; end
          M_LISTEN: begin
            if (valid[k]) begin
              l = int'(len[k*LEN_W +: LEN_W]);
              m_left[k]  = (l == 0) ? 1 : l;
              m_keyon[k] = 1;
              m_mode[k]  = M_PLAY;
            end else begin
              m_waited[k]++;
              if (m_waited[k] >= VT - 1) m_mode[k] = M_DEAD;
            end
          end
          M_PLAY: if (e_tick) begin
            if (m_left[k] == 1) m_mode[k] = M_ASK;
            else m_left[k]--;
          end
          default: ;
        endcase
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_rec();
    for (int k = 0; k < NUM_CH; k++) begin
      stb_cnt[k] = 0; first_stb[k] = -1; last_stb[k] = -1; keyon_cyc[k] = -1;
      stop_cyc[k] = -1; gate_ticks[k] = 0; gate_hi[k] = 0;
    end
    tick_total = 0; last_tick = -1; stb_vec_last = '0;
  endtask

  task automatic set_cfg(input int d, input int l);
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_delay[k] = d; cfg_len[k] = l; cfg_dead[k] = 0;
    end
    spur = 0; rand_drop = 0;
  endtask

  task automatic restart(input int per);
    rst = 1'b1; run = 1'b0; period = 16'(per);
    step();
    model_ok = 1;
    rst = 1'b0;
    clear_rec();
    #1;
    chk("reset_state", 32'({tick, stb, gate, key_on, stopped}), 32'd0);
    #1;
  endtask

  int c0, g0, t0, h0, s0;

  initial begin
    rst = 1'b1; run = 1'b0; period = 16'd4; valid = '0; len = '0;
    for (int k = 0; k < NUM_CH; k++) resp[k] = -1;
    set_cfg(5, 3);
    clear_rec();
    @(negedge clk);

    // 1: basic note, P=4, valid 5 clocks after strobe, len 3
    restart(4); set_cfg(5, 3); run = 1'b1;
    for (int i = 0; i < 80 && stb_cnt[0] < 2; i++) step();
    chk("t1_done", 32'(stb_cnt[0] >= 2), 32'd1);
    chk("t1_keyon_lat", 32'(keyon_cyc[0] - first_stb[0]), 32'd6);
    chk("t1_gate_ticks", 32'(gate_ticks[0]), 32'd3);
    chk("t1_restb", 32'(last_stb[0] - last_tick), 32'd1);

    // 2: period 0 ticks every clock; len 0 plays one tick
    restart(0); set_cfg(4, 0); run = 1'b1; c0 = cyc;
    for (int i = 0; i < 40 && stb_cnt[0] < 2; i++) step();
    chk("t2_done", 32'(stb_cnt[0] >= 2), 32'd1);
    chk("t2_gate_ticks", 32'(gate_ticks[0]), 32'd1);
    chk("t2_tick_every", 32'(tick_total), 32'(cyc - c0));

    // 3: pause with two ticks left
    restart(4); set_cfg(4, 4); run = 1'b1;
    for (int i = 0; i < 60 && !(m_mode[0] == M_PLAY && m_left[0] == 2); i++) step();
    chk("t3_reached", 32'(m_mode[0] == M_PLAY && m_left[0] == 2), 32'd1);
    g0 = gate_ticks[0]; t0 = tick_total; h0 = gate_hi[0]; run = 1'b0;
    repeat (20) step();
    chk("t3_no_tick", 32'(tick_total - t0), 32'd0);
    chk("t3_gate_held", 32'(gate_hi[0] - h0), 32'd20);
    run = 1'b1; s0 = stb_cnt[0];
    for (int i = 0; i < 40 && stb_cnt[0] == s0; i++) step();
    chk("t3_resume_ticks", 32'(gate_ticks[0] - g0), 32'd2);

    // 4: voice 1 never answers
    restart(3); set_cfg(5, 2); cfg_dead[1] = 1; run = 1'b1;
    repeat (70) step();
    chk("t4_stop_lat", 32'(stop_cyc[1] - first_stb[1]), 32'(VT));
    chk("t4_one_stb", 32'(stb_cnt[1]), 32'd1);
    chk("t4_others_run", 32'(stb_cnt[0] >= 2 && stb_cnt[2] >= 2 && stop_cyc[0] < 0 && stop_cyc[2] < 0), 32'd1);

    // 5: simultaneous expiry, spurious valids while playing
    restart(4); set_cfg(5, 2); spur = 1; run = 1'b1;
    for (int i = 0; i < 80 && stb_cnt[0] < 3; i++) step();
    chk("t5_sync", 32'(stb_vec_last), 32'h7);
    chk("t5_sync_cnt", 32'(stb_cnt[1] == stb_cnt[0] && stb_cnt[2] == stb_cnt[0] && stb_cnt[0] == 3), 32'd1);
    chk("t5_len_kept", 32'(gate_ticks[0]), 32'd2);

    // 6: reset mid-note
    restart(4); set_cfg(4, 5); run = 1'b1;
    for (int i = 0; i < 40 && m_mode[0] != M_PLAY; i++) step();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    chk("t6_cleared", 32'(last_outs), 32'd0);
    step();
    chk("t6_restb", 32'(last_outs[11:9]), 32'h7);

    // random soak
    restart(2); set_cfg(-1, -1); spur = 2; rand_drop = 1; run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 149) == 0) period = 16'($urandom_range(0, 5));
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
